// File: rtl/process_chain_n.sv
// rtl/process_chain_n.sv - N-channel gain/saturate/mono/mute stage with peak meters.
// One shared multiplier handles one channel per cycle; results land in audio_out on entry to OUT.
module process_chain_n #(
  parameter int WIDTH      = 18,
  parameter int CHANNELS   = 2,
  parameter int GAIN_BITS  = 5,
  parameter int METER_BITS = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           ready,
  input  logic [CHANNELS*WIDTH-1:0]      audio_in,
  input  logic [CHANNELS*GAIN_BITS-1:0]  gain,
  input  logic [1:0]                     mode,
  output logic [CHANNELS*WIDTH-1:0]      audio_out,
  output logic                           out_valid,
  output logic                           busy,
  output logic [CHANNELS*METER_BITS-1:0] level,
  output logic                           overrun
);

  localparam int LOG2 = $clog2(CHANNELS);
  localparam int IDXW = (LOG2 > 0) ? LOG2 : 1;
  localparam int PW   = WIDTH + GAIN_BITS + 1;
  localparam int SW   = WIDTH + LOG2;
  localparam logic signed [PW-1:0] SAT_MAX = {{(GAIN_BITS+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(GAIN_BITS+2){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_MIX, S_OUT} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [CHANNELS*WIDTH-1:0]       r_samp;
  logic [CHANNELS*GAIN_BITS-1:0]   r_gain;
  logic [1:0]                      r_mode;
  logic [IDXW-1:0]                 r_idx;
  logic signed [WIDTH-1:0]         r_res [CHANNELS];
  logic [CHANNELS*WIDTH-1:0]       r_out;
  logic [CHANNELS*METER_BITS-1:0]  r_level;
  logic                            r_overrun;

  logic                            w_last;
  logic signed [WIDTH-1:0]         w_sample;
  logic [GAIN_BITS-1:0]            w_gain;
  logic signed [PW-1:0]            w_a;
  logic signed [PW-1:0]            w_b;
  logic signed [PW-1:0]            w_prod;
  logic signed [PW-1:0]            w_shift;
  logic signed [WIDTH-1:0]         w_sat;
  logic signed [WIDTH-1:0]         w_calc;
  logic signed [SW-1:0]            w_sum;
  logic signed [WIDTH-1:0]         w_mix;
  logic signed [WIDTH-1:0]         w_res_next [CHANNELS];
  logic [WIDTH-1:0]                w_abs [CHANNELS];
  logic [METER_BITS-1:0]           w_mag [CHANNELS];
  logic [CHANNELS*METER_BITS-1:0]  w_level_next;

  assign w_last   = (r_idx == IDXW'(CHANNELS - 1));
  assign w_sample = r_samp[r_idx*WIDTH +: WIDTH];
  assign w_gain   = r_gain[r_idx*GAIN_BITS +: GAIN_BITS];

  // Signed sample times zero-extended gain, then divide by unity (16) with floor.
  assign w_a     = {{(GAIN_BITS+1){w_sample[WIDTH-1]}}, w_sample};
  assign w_b     = {{(WIDTH+1){1'b0}}, w_gain};
  assign w_prod  = w_a * w_b;
  assign w_shift = w_prod >>> 4;

  always_comb begin
    w_sat = w_shift[WIDTH-1:0];
    if (w_shift > SAT_MAX)      w_sat = S_MAX;
    else if (w_shift < SAT_MIN) w_sat = S_MIN;
  end

  always_comb begin
    w_calc = w_sat;
    case (r_mode)
      2'b00:   w_calc = w_sample;
      2'b11:   w_calc = '0;
      default: w_calc = w_sat;
    endcase
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < CHANNELS; k++) w_sum = w_sum + SW'(r_res[k]);
  end
  assign w_mix = WIDTH'(w_sum >>> LOG2);

  // Results as they will be after this edge, so audio_out and meters can load on OUT entry.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) w_res_next[k] = r_res[k];
    if (r_state == S_CALC) w_res_next[r_idx] = w_calc;
    else if (r_state == S_MIX)
      for (int k = 0; k < CHANNELS; k++) w_res_next[k] = w_mix;
  end

  always_comb begin
    w_level_next = r_level;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_res_next[k] == S_MIN)   w_abs[k] = S_MAX;
      else if (w_res_next[k] < 0)   w_abs[k] = -w_res_next[k];
      else                          w_abs[k] = w_res_next[k];
      w_mag[k] = w_abs[k][WIDTH-2 -: METER_BITS];
      if (w_mag[k] >= r_level[k*METER_BITS +: METER_BITS])
        w_level_next[k*METER_BITS +: METER_BITS] = w_mag[k];
      else
        w_level_next[k*METER_BITS +: METER_BITS] = r_level[k*METER_BITS +: METER_BITS] - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ready) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = (r_mode == 2'b10) ? S_MIX : S_OUT;
      S_MIX:   w_next = S_OUT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_OUT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_samp    <= '0;
      r_gain    <= '0;
      r_mode    <= '0;
      r_idx     <= '0;
      r_out     <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) r_res[k] <= '0;
    end else begin
      if (r_state == S_IDLE && ready) begin
        r_samp <= audio_in;
        r_gain <= gain;
        r_mode <= mode;
        r_idx  <= '0;
      end
      if (r_state == S_CALC) r_idx <= r_idx + 1'b1;
      for (int k = 0; k < CHANNELS; k++) r_res[k] <= w_res_next[k];
      if (w_next == S_OUT) begin
        for (int k = 0; k < CHANNELS; k++) r_out[k*WIDTH +: WIDTH] <= w_res_next[k];
        r_level <= w_level_next;
      end
      if (ready && r_state != S_IDLE) r_overrun <= 1'b1;
    end
  end

  assign audio_out = r_out;
  assign level     = r_level;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_process_chain_n.sv
// tb/tb_process_chain_n.sv - directed-vector bench for process_chain_n.
module tb_process_chain_n;

  localparam int WIDTH = 18;
  localparam int CH    = 2;
  localparam int GB    = 5;
  localparam int MB    = 8;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  ready = 1'b0;
  logic [CH*WIDTH-1:0]   audio_in = '0;
  logic [CH*GB-1:0]      gain = '0;
  logic [1:0]            mode = 2'b00;
  logic [CH*WIDTH-1:0]   audio_out;
  logic                  out_valid;
  logic                  busy;
  logic [CH*MB-1:0]      level;
  logic                  overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int lat, bcnt, vcnt;

  process_chain_n #(.WIDTH(WIDTH), .CHANNELS(CH), .GAIN_BITS(GB), .METER_BITS(MB)) dut (
    .clock(clock), .reset(reset), .ready(ready), .audio_in(audio_in), .gain(gain),
    .mode(mode), .audio_out(audio_out), .out_valid(out_valid), .busy(busy),
    .level(level), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint ch(input int k);
    logic signed [WIDTH-1:0] v;
    v = audio_out[k*WIDTH +: WIDTH];
    return longint'(v);
  endfunction

  function automatic longint lv(input int k);
    return longint'(level[k*MB +: MB]);
  endfunction

  task automatic load(input int l, input int r, input int gl, input int gr, input int md);
    audio_in = {WIDTH'(r), WIDTH'(l)};
    gain     = {GB'(gr), GB'(gl)};
    mode     = 2'(md);
  endtask

  // Watch ten cycles after the ready-sampling edge: first out_valid index, busy and valid counts.
  task automatic observe();
    lat = 0; bcnt = 0; vcnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (busy) bcnt++;
      if (out_valid) begin
        if (vcnt == 0) lat = i;
        vcnt++;
      end
      @(negedge clock);
    end
  endtask

  task automatic send(input int l, input int r, input int gl, input int gr, input int md);
    @(negedge clock);
    load(l, r, gl, gr, md);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    observe();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clock);
    check("rst_out", longint'(audio_out), 0);
    check("rst_level", longint'(level), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);

    send(1000, -1000, 16, 16, 1);
    check("unity_L", ch(0), 1000);
    check("unity_R", ch(1), -1000);
    check("unity_latency", lat, 3);
    check("unity_busy", bcnt, 3);
    check("unity_nvalid", vcnt, 1);

    send(100000, -131072, 31, 31, 1);
    check("sat_L", ch(0), 131071);
    check("sat_R", ch(1), -131072);
    send(-3, 5, 8, 8, 1);
    check("floor_L", ch(0), -2);
    check("half_R", ch(1), 2);

    send(7, -7, 16, 16, 0);
    check("bypass_L", ch(0), 7);
    check("bypass_R", ch(1), -7);

    send(2000, -1000, 16, 16, 2);
    check("mono_L", ch(0), 500);
    check("mono_R", ch(1), 500);
    check("mono_latency", lat, 4);
    check("mono_busy", bcnt, 4);
    send(-3, 0, 16, 16, 2);
    check("mono_floor_L", ch(0), -2);
    check("mono_floor_R", ch(1), -2);
    check("no_overrun_yet", longint'(overrun), 0);

    // Back-to-back ready: the second sample is dropped.
    @(negedge clock);
    load(111, 222, 16, 16, 1);
    ready = 1'b1;
    @(negedge clock);
    load(333, 444, 16, 16, 1);
    @(negedge clock);
    ready = 1'b0;
    observe();
    check("ovr_nvalid", vcnt, 1);
    check("ovr_first_L", ch(0), 111);
    check("ovr_first_R", ch(1), 222);
    check("ovr_flag", longint'(overrun), 1);
    send(10, 20, 16, 16, 1);
    check("ovr_sticky", longint'(overrun), 1);

    do_reset();
    check("ovr_cleared", longint'(overrun), 0);

    // Ready in the first IDLE cycle after OUT is accepted.
    @(negedge clock);
    load(50, 60, 16, 16, 1);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clock);
    check("idle_wait_valid", longint'(out_valid), 1);
    @(negedge clock);
    load(70, -80, 16, 16, 1);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    observe();
    check("idle_accept_nvalid", vcnt, 1);
    check("idle_accept_L", ch(0), 70);
    check("idle_accept_R", ch(1), -80);
    check("idle_accept_ovr", longint'(overrun), 0);

    do_reset();
    send(131071, 0, 16, 16, 1);
    check("meter_peak_L", lv(0), 255);
    check("meter_peak_R", lv(1), 0);
    send(131071, 0, 16, 16, 3);
    check("meter_decay1", lv(0), 254);
    check("mute_L", ch(0), 0);
    send(131071, 0, 16, 16, 3);
    check("meter_decay2", lv(0), 253);
    send(131071, 0, 16, 16, 3);
    check("meter_decay3", lv(0), 252);
    check("meter_R_floor", lv(1), 0);

    send(-131072, 512, 16, 16, 1);
    check("meter_minneg_L", lv(0), 255);
    check("meter_R_small", lv(1), 1);

    // Abort during CALC.
    @(negedge clock);
    load(1234, 5678, 16, 16, 1);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    check("abort_in_calc", longint'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_out", longint'(audio_out), 0);
    check("abort_level", longint'(level), 0);
    @(negedge clock);
    reset = 1'b0;
    observe();
    check("abort_nvalid", vcnt, 0);
    check("abort_busy", bcnt, 0);
    check("abort_out_after", longint'(audio_out), 0);
    check("abort_overrun", longint'(overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
